ncc_sequencer: RTL and testbench

NCC_SEQUENCER -- requirements
Module: ncc_sequencer

---
 rtl/ncc_sequencer_pkg.sv | 19 +
 rtl/ncc_sequencer_counter.sv | 28 ++
 rtl/ncc_sequencer.sv | 143 ++++++++++++++
 tb/tb_ncc_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncc_sequencer_pkg.sv
// Shared types and default sizing for the NCC sequencer: FSM state encoding,
// default template/window/array dimensions and the descriptor word type.
package ncc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESC,
    ST_WIN,
    ST_DRAIN,
    ST_FIN
  } ncc_state_e;

  localparam int DESC_WORDS_DEF = 64;
  localparam int WIN_PIXELS_DEF = 640;
  localparam int PE_COLS_DEF    = 16;

  typedef logic [31:0] desc_word_t;

endpackage

// File: rtl/ncc_sequencer_counter.sv
// Clearable up-counter used for the descriptor, pixel and drain indices.
// The owner decides when to stop incrementing, so the count never wraps.
module ncc_sequencer_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Clear has priority over increment so a restart always begins at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ncc_sequencer.sv
// NCC match sequencer: loads the template descriptor into the PE array, streams
// window pixels, drains the accumulation chain and pulses done.
// Optional abort input is enabled by defining NCC_SEQ_ABORT_EN.
module ncc_sequencer
  import ncc_pkg::*;
#(
  parameter int DESC_WORDS = DESC_WORDS_DEF,
  parameter int WIN_PIXELS = WIN_PIXELS_DEF,
  parameter int PE_COLS    = PE_COLS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       desc_valid,
  input  desc_word_t desc_data_in,
  output logic       desc_ready,
  input  logic       win_valid,
  output logic       win_ready,
  output desc_word_t desc_data_out,
  output logic       loadDescNow,
  output logic [3:0] descRow,
  output logic [1:0] descColGroup,
  output logic       loadWinReg,
  output logic       loadAccSumReg,
  output logic       result_valid,
  output logic       busy,
  output logic       done
`ifdef NCC_SEQ_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int DW = $clog2(DESC_WORDS);
  localparam int PW = $clog2(WIN_PIXELS);
  localparam int CW = $clog2(PE_COLS);

  ncc_state_e state_q;
  logic       load_desc_q;
  desc_word_t desc_data_q;
  logic [3:0] desc_row_q;
  logic [1:0] desc_col_q;
  logic       result_q;

  logic [DW-1:0] desc_cnt;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] drain_cnt;
  logic [5:0]    desc_idx6;

  logic abort_w, run_start, cnt_clr;
  logic desc_hs, win_hs, drain_act;
  logic desc_last, pix_last, drain_last;

`ifdef NCC_SEQ_ABORT_EN
  assign abort_w = abort & (state_q != ST_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign run_start = (state_q == ST_IDLE) & start;
  assign cnt_clr   = run_start | abort_w;

  assign desc_ready = (state_q == ST_DESC);
  assign win_ready  = (state_q == ST_WIN);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);

  // An abort cycle accepts nothing, so the array sees no partial update.
  assign desc_hs   = desc_valid & desc_ready & ~abort_w;
  assign win_hs    = win_valid & win_ready & ~abort_w;
  assign drain_act = (state_q == ST_DRAIN) & ~abort_w;

  assign desc_last  = (desc_cnt == DW'(DESC_WORDS - 1));
  assign pix_last   = (pix_cnt == PW'(WIN_PIXELS - 1));
  assign drain_last = (drain_cnt == CW'(PE_COLS - 2));

  assign loadWinReg    = win_hs;
  assign loadAccSumReg = win_hs | drain_act;

  // Row/column-group select is taken from a 6-bit view of the word index.
  generate
    if (DW >= 6) begin : g_idx_wide
      assign desc_idx6 = desc_cnt[5:0];
    end else begin : g_idx_narrow
      assign desc_idx6 = {{(6 - DW){1'b0}}, desc_cnt};
    end
  endgenerate

  // Counters stop on their final index, so none can wrap within a run.
  ncc_sequencer_counter #(.WIDTH(DW)) u_desc_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr),
    .inc_i(desc_hs & ~desc_last), .count_o(desc_cnt)
  );

  ncc_sequencer_counter #(.WIDTH(PW)) u_pix_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr),
    .inc_i(win_hs & ~pix_last), .count_o(pix_cnt)
  );

  ncc_sequencer_counter #(.WIDTH(CW)) u_drain_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr),
    .inc_i(drain_act & ~drain_last), .count_o(drain_cnt)
  );

  // Run-control FSM with registered descriptor strobe and result flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_desc_q <= 1'b0;
      desc_data_q <= '0;
      desc_row_q  <= '0;
      desc_col_q  <= '0;
      result_q    <= 1'b0;
    end else begin
      load_desc_q <= desc_hs;
      result_q    <= (win_hs & (pix_cnt >= PW'(PE_COLS - 1))) | drain_act;
      if (desc_hs) begin
        desc_data_q <= desc_data_in;
        desc_row_q  <= desc_idx6[5:2];
        desc_col_q  <= desc_idx6[1:0];
      end
      if (abort_w) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE:  if (start) state_q <= ST_DESC;
          ST_DESC:  if (desc_hs && desc_last) state_q <= ST_WIN;
          ST_WIN:   if (win_hs && pix_last) state_q <= ST_DRAIN;
          ST_DRAIN: if (drain_last) state_q <= ST_FIN;
          ST_FIN:   state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign loadDescNow   = load_desc_q;
  assign desc_data_out = desc_data_q;
  assign descRow       = desc_row_q;
  assign descColGroup  = desc_col_q;
  assign result_valid  = result_q;

endmodule

// File: tb/tb_ncc_sequencer.sv
// Directed bench for ncc_sequencer with a cycle-stamped scoreboard.
// Define NCC_SEQ_ABORT_EN to also exercise the abort input.
module tb_ncc_sequencer;
  import ncc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       desc_valid = 1'b0;
  desc_word_t desc_data_in = '0;
  logic       win_valid = 1'b0;
`ifdef NCC_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       desc_ready, win_ready, loadDescNow, loadWinReg, loadAccSumReg;
  logic       result_valid, busy, done;
  desc_word_t desc_data_out;
  logic [3:0] descRow;
  logic [1:0] descColGroup;

  ncc_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .desc_valid(desc_valid), .desc_data_in(desc_data_in), .desc_ready(desc_ready),
    .win_valid(win_valid), .win_ready(win_ready),
    .desc_data_out(desc_data_out), .loadDescNow(loadDescNow),
    .descRow(descRow), .descColGroup(descColGroup),
    .loadWinReg(loadWinReg), .loadAccSumReg(loadAccSumReg),
    .result_valid(result_valid), .busy(busy), .done(done)
`ifdef NCC_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int         cyc;
    int         idx;
    logic [31:0] data;
  } desc_exp_t;

  desc_exp_t desc_q[$];
  int        win_q[$];
  int        res_q[$];
  int        done_q[$];
  int        desc_seen, win_seen, res_seen, drain_seen, done_seen;
  desc_exp_t e_mon;
  logic [5:0] iv_mon;
  int        i_mon;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output event must match the front of its queue by cycle.
  always @(negedge clk) begin
    while (desc_q.size() > 0 && desc_q[0].cyc < cyc) begin
      e_mon = desc_q.pop_front();
      check("desc_strobe_missing", cyc, e_mon.cyc);
    end
    while (win_q.size() > 0 && win_q[0] < cyc) begin
      i_mon = win_q.pop_front();
      check("win_strobe_missing", cyc, i_mon);
    end
    while (res_q.size() > 0 && res_q[0] < cyc) begin
      i_mon = res_q.pop_front();
      check("result_missing", cyc, i_mon);
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      i_mon = done_q.pop_front();
      check("done_missing", cyc, i_mon);
    end
    if (loadDescNow === 1'b1) begin
      desc_seen++;
      if (desc_q.size() == 0) check("desc_strobe_unexpected", loadDescNow, 0);
      else begin
        e_mon  = desc_q.pop_front();
        iv_mon = e_mon.idx[5:0];
        check("desc_strobe_cycle", cyc, e_mon.cyc);
        check("desc_data_out", desc_data_out, e_mon.data);
        check("descRow", descRow, iv_mon[5:2]);
        check("descColGroup", descColGroup, iv_mon[1:0]);
        if (e_mon.idx == 5) begin
          check("word5_row", descRow, 1);
          check("word5_col", descColGroup, 1);
        end
        if (e_mon.idx == 63) begin
          check("word63_row", descRow, 15);
          check("word63_col", descColGroup, 3);
        end
      end
    end
    if (loadWinReg === 1'b1) begin
      win_seen++;
      check("acc_with_win", loadAccSumReg, 1);
      if (win_q.size() == 0) check("win_strobe_unexpected", loadWinReg, 0);
      else begin
        i_mon = win_q.pop_front();
        check("win_strobe_cycle", cyc, i_mon);
      end
    end
    if (loadAccSumReg === 1'b1 && loadWinReg !== 1'b1) drain_seen++;
    if (result_valid === 1'b1) begin
      res_seen++;
      if (res_q.size() == 0) check("result_unexpected", result_valid, 0);
      else begin
        i_mon = res_q.pop_front();
        check("result_cycle", cyc, i_mon);
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      if (done_q.size() == 0) check("done_unexpected", done, 0);
      else begin
        i_mon = done_q.pop_front();
        check("done_cycle", cyc, i_mon);
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_desc_ready"}, desc_ready, 0);
    check({pfx, "_win_ready"}, win_ready, 0);
    check({pfx, "_desc_data_out"}, desc_data_out, 0);
    check({pfx, "_loadDescNow"}, loadDescNow, 0);
    check({pfx, "_descRow"}, descRow, 0);
    check({pfx, "_descColGroup"}, descColGroup, 0);
    check({pfx, "_loadWinReg"}, loadWinReg, 0);
    check({pfx, "_loadAccSumReg"}, loadAccSumReg, 0);
    check({pfx, "_result_valid"}, result_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
  endtask

  task automatic start_run();
    desc_seen = 0; win_seen = 0; res_seen = 0; drain_seen = 0; done_seen = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("desc_ready_after_start", desc_ready, 1);
    check("busy_after_start", busy, 1);
  endtask

  // Drives nwords descriptor words; returns in the cycle of the final strobe.
  task automatic load_desc(input int nwords, input bit bubbles);
    for (int n = 0; n < nwords; n++) begin
      if (bubbles && n > 0) begin
        tick();
        desc_valid = 1'b0;
      end
      tick();
      desc_valid   = 1'b1;
      desc_data_in = $urandom();
      desc_q.push_back('{cyc + 1, n, desc_data_in});
    end
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic check_full_load();
    check("last_strobe_present", loadDescNow, 1);
    check("win_state_on_last_strobe", win_ready, 1);
    check("desc_ready_off_in_win", desc_ready, 0);
  endtask

  task automatic run_window(input bit gap, input bit start_mid);
    int klast;
    klast = 0;
    for (int i = 0; i < 640; i++) begin
      tick();
      start     = 1'b0;
      win_valid = 1'b1;
      win_q.push_back(cyc);
      if (i >= 15) res_q.push_back(cyc + 1);
      klast = cyc;
      if (start_mid && i == 300) start = 1'b1;
      if (gap) begin
        tick();
        win_valid = 1'b0;
        start     = 1'b0;
        if (start_mid && i == 300) begin
          check("start_in_win_desc_ready", desc_ready, 0);
          check("start_in_win_win_ready", win_ready, 1);
        end
      end
    end
    tick();
    win_valid = 1'b0;
    start     = 1'b0;
    for (int d = 0; d < 15; d++) res_q.push_back(klast + 2 + d);
    done_q.push_back(klast + 16);
    repeat (20) tick();
    check("desc_strobe_count", desc_seen, 64);
    check("win_strobe_count", win_seen, 640);
    check("result_count", res_seen, 640);
    check("drain_strobe_count", drain_seen, 15);
    check("done_count", done_seen, 1);
    check("busy_after_run", busy, 0);
    check("queues_empty", desc_q.size() + win_q.size() + res_q.size() + done_q.size(), 0);
  endtask

  initial begin
    #2;
    check_all_zero("reset_state");
    repeat (2) tick();
    rst = 1'b0;

    // Partial load, then reset mid-descriptor.
    start_run();
    load_desc(11, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_desc");
    tick();
    tick();
    rst = 1'b0;
    check("desc_q_empty_after_rst", desc_q.size(), 0);

    // Reload from word 0 with bubbles, window every other cycle, start in WIN.
    start_run();
    load_desc(64, 1'b1);
    check_full_load();
    run_window(1'b1, 1'b1);

    // Back-to-back descriptor load and continuous window.
    start_run();
    load_desc(64, 1'b0);
    check_full_load();
    run_window(1'b0, 1'b0);

`ifdef NCC_SEQ_ABORT_EN
    start_run();
    load_desc(64, 1'b0);
    check_full_load();
    for (int i = 0; i <= 300; i++) begin
      tick();
      win_valid = 1'b1;
      win_q.push_back(cyc);
      if (i >= 15) res_q.push_back(cyc + 1);
      tick();
      win_valid = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_win_ready", win_ready, 0);
    repeat (20) tick();
    check("abort_no_done", done_seen, 0);
    check("abort_win_count", win_seen, 301);
    check("abort_queues_empty", desc_q.size() + win_q.size() + res_q.size() + done_q.size(), 0);

    start_run();
    load_desc(64, 1'b0);
    check_full_load();
    run_window(1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
